alu_dispatch_router: RTL
========================

Name: alu_dispatch_router

Overview:
- In-order dispatch stage directly upstream of the ALU reservation buffer.
- Accepts up to two fetched instructions per cycle and stamps each with a 32-bit program-order instruction number.
- Queues them and routes each to either the ALU buffer port or the non-ALU (branch/other) port using valid/ready handshakes.
- Supplies the Instr/InstrNO/DR triple the ALU buffer consumes.

Parameters:
- DEPTH, 8, queue entries (power of two, >=4)
- PTRW, 3, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all queued, undispatched instructions
- fetch_valid0  in  1  slot 0 instruction valid (older)
- fetch_instr0  in  32  slot 0 instruction word
- fetch_valid1  in  1  slot 1 instruction valid (younger; only honoured with fetch_valid0)
- fetch_instr1  in  32  slot 1 instruction word
- fetch_ready  out  1  queue can take two instructions this cycle
- alu_instr  out  32  instruction to ALU buffer
- alu_instr_no  out  32  its instruction number
- alu_dr  out  1  alu_instr valid
- alu_ready  in  1  ALU buffer can accept (ALUbuffer_ready)
- oth_instr  out  32  instruction to non-ALU path
- oth_instr_no  out  32  its instruction number
- oth_dr  out  1  oth_instr valid
- oth_ready  in  1  non-ALU path can accept
- q_count  out  PTRW+1  current occupancy

Behaviour:
- Classification at enqueue, stored as a 1-bit class with the entry.
  - ALU if opcode [31:26] is one of: 000000, 000110, 001000, 001001, 001011, 001100, 001101, 001110, 001111, 100011, 101011.
  - Every other opcode is OTH.
- Reset: queue empty, head = tail = 0, next_no = 1, q_count = 0, fetch_ready = 1, alu_dr = 0, oth_dr = 0, all data outputs 0.
- fetch_ready = (DEPTH - q_count) >= 2. Combinational from registered state only; does not depend on this cycle's pops.
- Enqueue at posedge, only if fetch_ready and not flush:
  - fetch_valid0 only: slot 0 written with number next_no; next_no += 1.
  - Both valid: slot 0 gets next_no, slot 1 gets next_no+1, in queue order; next_no += 2.
  - fetch_valid1 without fetch_valid0: ignored.
  - fetch_valid with fetch_ready=0: ignored; fetch must hold its instructions.
- Numbering:
  - next_no wraps modulo 2^32; value 0 is skipped on wrap (0xFFFFFFFF is followed by 1).
  - next_no is never reset by flush.
- Output ports (combinational from queue head, no added latency; an instruction enqueued at edge k is presentable in cycle k+1):
  - H = entry at head. If queue non-empty and H.class=ALU: alu_dr=1, alu_instr/alu_instr_no = H. If H.class=OTH: oth_dr=1, oth_* = H.
  - H1 = head+1 entry. If q_count>=2 and H1.class differs from H.class, H1 drives the other port's *_dr/data.
  - An undriven port has dr=0 and data held at last value.
- Pop at posedge, strictly in order:
  - H pops if its port's ready=1.
  - H1 pops in the same cycle only if H pops, H1 is presented, and H1's port ready=1.
  - A younger entry never leaves before an older one. Max 2 pops per cycle.
- Simultaneous enqueue and pop in one cycle: q_count_next = q_count + pushes - pops. Pointers wrap modulo DEPTH.
- Full: q_count=DEPTH-1 or DEPTH gives fetch_ready=0. Pops continue.
- Empty: both dr=0, nothing pops.
- Flush at posedge:
  - head = tail, q_count = 0, both dr=0 from the next cycle.
  - Same-cycle fetch inputs are dropped; same-cycle pops are void; nothing is consumed downstream.
- rst overrides flush and all activity. Reset mid-stream discards the queue and restarts numbering at 1.
- Downstream must sample on a posedge where dr && ready. The handshake is a full transfer; dr does not need to deassert between back-to-back items.

Test Plan:
- Reset, then slot0=0x012A4020 (add), slot1=0x08000010 (j), both valid, ready both 1 -> next cycle alu_dr=1 no=1 and oth_dr=1 no=2 simultaneously; both popped; q_count back to 0.
- Four ALU instrs (addi 0x20010005 ×4) in two fetch cycles, alu_ready=0 -> q_count=4, alu_instr_no=1 held; raise alu_ready -> numbers 1,2,3,4 on consecutive cycles, one pop per cycle.
- Head OTH with oth_ready=0, next ALU with alu_ready=1 -> neither pops (in-order); q_count unchanged until oth_ready=1, then both pop together.
- Fill queue to 7 with alu_ready=0 -> fetch_ready=0; offered pair ignored and next_no unchanged; one pop -> q_count=6, fetch_ready=1.
- Load 5 entries, assert flush with a valid fetch pair -> q_count=0, dr=0 next cycle; next accepted instruction gets number 6 (not 1).
- Force next_no=0xFFFFFFFF via long run or backdoor, enqueue two -> numbers 0xFFFFFFFF then 1; pointer wrap past DEPTH keeps FIFO order.

Source files
------------

// File: rtl/alu_dispatch_router.sv
// rtl/alu_dispatch_router.sv - dual-issue in-order dispatch queue feeding ALU and non-ALU ports
module alu_dispatch_router #(
   parameter int DEPTH = 8,
   parameter int PTRW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            fetch_valid0,
   input  logic [31:0]     fetch_instr0,
   input  logic            fetch_valid1,
   input  logic [31:0]     fetch_instr1,
   output logic            fetch_ready,
   output logic [31:0]     alu_instr,
   output logic [31:0]     alu_instr_no,
   output logic            alu_dr,
   input  logic            alu_ready,
   output logic [31:0]     oth_instr,
   output logic [31:0]     oth_instr_no,
   output logic            oth_dr,
   input  logic            oth_ready,
   output logic [PTRW:0]   q_count
);

   localparam logic [PTRW:0] CNT_ZERO = '0;
   localparam logic [PTRW:0] CNT_ONE  = (PTRW+1)'(1);
   localparam logic [PTRW:0] CNT_ROOM = (PTRW+1)'(DEPTH - 2);

   function automatic logic is_alu_op(input logic [5:0] op);
      case (op)
         6'b000000, 6'b000110, 6'b001000, 6'b001001, 6'b001011, 6'b001100,
         6'b001101, 6'b001110, 6'b001111, 6'b100011, 6'b101011: is_alu_op = 1'b1;
         default: is_alu_op = 1'b0;
      endcase
   endfunction

   // Instruction numbers never take the value 0.
   function automatic logic [31:0] next_num(input logic [31:0] n);
      next_num = (n == 32'hFFFF_FFFF) ? 32'd1 : n + 32'd1;
   endfunction

   logic [31:0]     instr_q [DEPTH];
   logic [31:0]     instr_d [DEPTH];
   logic [31:0]     no_q    [DEPTH];
   logic [31:0]     no_d    [DEPTH];
   logic [DEPTH-1:0] cls_q, cls_d;
   logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, h1_ptr;
   logic [PTRW:0]   count_q, count_d;
   logic [31:0]     next_no_q, next_no_d;
   logic [31:0]     alu_instr_q, alu_instr_d, alu_no_q, alu_no_d;
   logic [31:0]     oth_instr_q, oth_instr_d, oth_no_q, oth_no_d;

   logic h_valid, h_cls, h1_cls, h1_pres;
   logic [31:0] alu_pi, alu_pn, oth_pi, oth_pn;
   logic push0, push1, pop0, pop1;

   assign fetch_ready = (count_q <= CNT_ROOM);
   assign q_count     = count_q;

   always_comb begin
      h1_ptr  = head_q + PTRW'(1);
      h_valid = (count_q != CNT_ZERO);
      h_cls   = cls_q[head_q];
      h1_cls  = cls_q[h1_ptr];
      h1_pres = (count_q > CNT_ONE) && (h1_cls != h_cls);
      alu_dr  = h_valid && (h_cls || h1_pres);
      oth_dr  = h_valid && (!h_cls || h1_pres);
      alu_pi  = h_cls ? instr_q[head_q] : instr_q[h1_ptr];
      alu_pn  = h_cls ? no_q[head_q]    : no_q[h1_ptr];
      oth_pi  = h_cls ? instr_q[h1_ptr] : instr_q[head_q];
      oth_pn  = h_cls ? no_q[h1_ptr]    : no_q[head_q];
      alu_instr    = alu_dr ? alu_pi : alu_instr_q;
      alu_instr_no = alu_dr ? alu_pn : alu_no_q;
      oth_instr    = oth_dr ? oth_pi : oth_instr_q;
      oth_instr_no = oth_dr ? oth_pn : oth_no_q;
   end

   always_comb begin
      instr_d     = instr_q;
      no_d        = no_q;
      cls_d       = cls_q;
      push0       = fetch_ready && fetch_valid0 && !flush;
      push1       = push0 && fetch_valid1;
      pop0        = !flush && h_valid && (h_cls ? alu_ready : oth_ready);
      pop1        = pop0 && h1_pres && (h1_cls ? alu_ready : oth_ready);
      next_no_d   = next_no_q;
      alu_instr_d = alu_instr;
      alu_no_d    = alu_instr_no;
      oth_instr_d = oth_instr;
      oth_no_d    = oth_instr_no;
      if (push0) begin
         instr_d[tail_q] = fetch_instr0;
         no_d[tail_q]    = next_no_q;
         cls_d[tail_q]   = is_alu_op(fetch_instr0[31:26]);
         next_no_d       = next_num(next_no_q);
      end
      if (push1) begin
         instr_d[tail_q + PTRW'(1)] = fetch_instr1;
         no_d[tail_q + PTRW'(1)]    = next_num(next_no_q);
         cls_d[tail_q + PTRW'(1)]   = is_alu_op(fetch_instr1[31:26]);
         next_no_d                  = next_num(next_num(next_no_q));
      end
      tail_d  = tail_q + PTRW'(push0) + PTRW'(push1);
      head_d  = head_q + PTRW'(pop0) + PTRW'(pop1);
      count_d = count_q + (PTRW+1)'(push0) + (PTRW+1)'(push1)
                        - (PTRW+1)'(pop0) - (PTRW+1)'(pop1);
      if (flush) begin
         head_d  = tail_q;
         tail_d  = tail_q;
         count_d = CNT_ZERO;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         cls_q       <= '0;
         next_no_q   <= 32'd1;
         alu_instr_q <= '0;
         alu_no_q    <= '0;
         oth_instr_q <= '0;
         oth_no_q    <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         cls_q       <= cls_d;
         next_no_q   <= next_no_d;
         alu_instr_q <= alu_instr_d;
         alu_no_q    <= alu_no_d;
         oth_instr_q <= oth_instr_d;
         oth_no_q    <= oth_no_d;
      end
   end

   // Payload storage needs no reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      no_q    <= no_d;
   end

endmodule
